acc_signed: RTL

// - Sequential signed accumulator directly downstream of the combinational signed multiplier.
// - Consumes a stream of IN_SIZE-bit signed products over a valid/ready handshake.
// - Sums one group of up to LEN products and presents the dot-product result over valid/ready.
// - Wrap or saturation on overflow is selected at elaboration; a sticky overflow flag goes with each result.

---
 rtl/acc_signed.sv | 112 +++++++++++
 1 files changed

// File: rtl/acc_signed.sv
// Signed group accumulator: sums up to LEN signed products per group and hands the
// total out over valid/ready, with elaboration-time wrap/saturate and a sticky overflow flag.
module acc_signed #(
  parameter int unsigned IN_SIZE  = 12,
  parameter int unsigned ACC_SIZE = 14,
  parameter int unsigned LEN      = 8,
  parameter int unsigned SATURATE = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [IN_SIZE-1:0]  in_data_i,
  input  logic                in_last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [ACC_SIZE-1:0] out_data_o,
  output logic                out_ovf_o
);

  localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  typedef enum logic {S_ACC, S_OUT} state_t;

  state_t                     r_state;
  logic signed [ACC_SIZE-1:0] r_acc;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_ovf;
  logic                       r_in_ready;
  logic                       r_out_valid;
  logic [ACC_SIZE-1:0]        r_out_data;
  logic                       r_out_ovf;

  logic signed [ACC_SIZE-1:0] w_base;
  logic signed [ACC_SIZE:0]   w_sum;
  logic                       w_sum_ovf;
  logic signed [ACC_SIZE-1:0] w_next;
  logic                       w_accept;
  logic                       w_final;

  // One guard bit is enough: both operands fit in ACC_SIZE signed bits.
  always_comb begin
    w_base    = (r_cnt == '0) ? '0 : r_acc;
    w_sum     = (ACC_SIZE+1)'(w_base) + (ACC_SIZE+1)'($signed(in_data_i));
    w_sum_ovf = w_sum[ACC_SIZE] ^ w_sum[ACC_SIZE-1];
    if (w_sum_ovf && (SATURATE != 0))
      w_next = w_sum[ACC_SIZE] ? {1'b1, {(ACC_SIZE-1){1'b0}}} : {1'b0, {(ACC_SIZE-1){1'b1}}};
    else
      w_next = w_sum[ACC_SIZE-1:0];
    w_accept = (r_state == S_ACC) && in_valid_i && r_in_ready;
    w_final  = in_last_i || (r_cnt == CNT_LAST);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else if (clear_i) begin
      r_state     <= S_ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_ACC: begin
          // ready rises on the first clock after reset release
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_acc <= w_next;
            r_ovf <= r_ovf | w_sum_ovf;
            if (w_final) begin
              r_state     <= S_OUT;
              r_cnt       <= '0;
              r_out_data  <= w_next;
              r_out_ovf   <= r_ovf | w_sum_ovf;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_OUT: begin
          if (out_ready_i) begin
            r_state     <= S_ACC;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= S_ACC;
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_ovf_o   = r_out_ovf;

endmodule
